// File: rtl/vga_timing_gen.sv
// vga_timing_gen: parametrised VGA raster timing generator.
// Counts pixels and lines, and produces registered sync, data-enable,
// pixel coordinates and line/frame strobes for the pixel fetch stage.
// Colour from upstream reaches the DAC pins only when o_de is high.
// A pixel advances once every PIX_DIV clocks while i_enable is high.
// Optional build macro: VGA_TEST_PATTERN_EN adds i_pattern_sel, which
// replaces the upstream colour with eight vertical colour bars.
module vga_timing_gen #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter logic H_SYNC_POL = 1'b0,
  parameter logic V_SYNC_POL = 1'b0,
  parameter int   PIX_DIV    = 1,
  parameter int   CW         = 4,
  localparam int  H_TOTAL    = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int  V_TOTAL    = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int  XW         = $clog2(H_TOTAL),
  localparam int  YW         = $clog2(V_TOTAL)
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_enable,
`ifdef VGA_TEST_PATTERN_EN
  input  logic            i_pattern_sel,
`endif
  input  logic [3*CW-1:0] i_color,
  output logic            o_hsync,
  output logic            o_vsync,
  output logic            o_de,
  output logic [XW-1:0]   o_x,
  output logic [YW-1:0]   o_y,
  output logic            o_pixel_ce,
  output logic            o_line_start,
  output logic            o_frame_start,
  output logic [CW-1:0]   o_red,
  output logic [CW-1:0]   o_green,
  output logic [CW-1:0]   o_blue
);

  // Zero-width regions or a zero prescale make the raster meaningless,
  // so refuse to elaborate rather than produce a broken timing chain.
  generate
    if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
        V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 ||
        PIX_DIV < 1 || CW < 1) begin : g_bad_params
      $error("vga_timing_gen: every region width, PIX_DIV and CW must be >= 1");
    end
  endgenerate

  // Prescaler width; a single bit is kept even when PIX_DIV is 1.
  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);

  // Horizontal region boundaries, expressed in counter width.
  localparam logic [XW-1:0] H_LAST      = XW'(H_TOTAL - 1);
  localparam logic [XW-1:0] H_ACT_END   = XW'(H_ACTIVE);
  localparam logic [XW-1:0] H_SYNC_BEG  = XW'(H_ACTIVE + H_FP);
  localparam logic [XW-1:0] H_SYNC_END  = XW'(H_ACTIVE + H_FP + H_SYNC);

  // Vertical region boundaries, expressed in counter width.
  localparam logic [YW-1:0] V_LAST      = YW'(V_TOTAL - 1);
  localparam logic [YW-1:0] V_ACT_END   = YW'(V_ACTIVE);
  localparam logic [YW-1:0] V_SYNC_BEG  = YW'(V_ACTIVE + V_FP);
  localparam logic [YW-1:0] V_SYNC_END  = YW'(V_ACTIVE + V_FP + V_SYNC);

  // Raster counters.
  logic [DW-1:0] r_div;
  logic [XW-1:0] r_h;
  logic [YW-1:0] r_v;

  // Registered timing outputs.
  logic          r_hsync;
  logic          r_vsync;
  logic          r_de;
  logic [XW-1:0] r_x;
  logic [YW-1:0] r_y;
  logic          r_pixel_ce;
  logic          r_line_start;
  logic          r_frame_start;

  // Decodes of the current raster position.
  logic w_tick;
  logic w_h_last;
  logic w_v_last;
  logic w_h_active;
  logic w_v_active;
  logic w_h_sync;
  logic w_v_sync;

  assign w_tick     = i_enable && (r_div == '0);
  assign w_h_last   = (r_h == H_LAST);
  assign w_v_last   = (r_v == V_LAST);
  assign w_h_active = (r_h < H_ACT_END);
  assign w_v_active = (r_v < V_ACT_END);
  assign w_h_sync   = (r_h >= H_SYNC_BEG) && (r_h < H_SYNC_END);
  assign w_v_sync   = (r_v >= V_SYNC_BEG) && (r_v < V_SYNC_END);

  // Prescaler and raster position counters; i_enable low parks them at origin.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else if (!i_enable) begin
      r_div <= '0;
      r_h   <= '0;
      r_v   <= '0;
    end else begin
      r_div <= (r_div == DIV_LAST) ? '0 : r_div + DW'(1);
      if (w_tick) begin
        if (w_h_last) begin
          r_h <= '0;
          r_v <= w_v_last ? '0 : r_v + YW'(1);
        end else begin
          r_h <= r_h + XW'(1);
        end
      end
    end
  end

  // Output register: loads the decoded position on a tick, strobes last one cycle.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pixel_ce    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (!i_enable) begin
      r_hsync       <= ~H_SYNC_POL;
      r_vsync       <= ~V_SYNC_POL;
      r_de          <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_pixel_ce    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (w_tick) begin
      r_hsync       <= w_h_sync ? H_SYNC_POL : ~H_SYNC_POL;
      r_vsync       <= w_v_sync ? V_SYNC_POL : ~V_SYNC_POL;
      r_de          <= w_h_active && w_v_active;
      r_x           <= r_h;
      r_y           <= r_v;
      r_pixel_ce    <= 1'b1;
      r_line_start  <= (r_h == '0);
      r_frame_start <= (r_h == '0) && (r_v == '0);
    end else begin
      r_pixel_ce    <= 1'b0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end
  end

  // Colour source: upstream colour, or the bar pattern when selected.
  logic [3*CW-1:0] w_src;
  logic [3*CW-1:0] w_rgb;

`ifdef VGA_TEST_PATTERN_EN
  // Bars are H_ACTIVE/8 pixels wide; narrow screens fall back to 1-pixel bars
  // and any remainder columns at the right edge stay on the last bar.
  localparam int BAR_W = ((H_ACTIVE / 8) > 0) ? (H_ACTIVE / 8) : 1;
  localparam int QW    = ((XW > 3) ? XW : 3) + 1;

  logic [QW-1:0]   w_bar_q;
  logic [2:0]      w_bar;
  logic [3*CW-1:0] w_pattern;

  assign w_bar_q   = QW'(r_x) / QW'(BAR_W);
  assign w_bar     = (w_bar_q > QW'(7)) ? 3'd7 : w_bar_q[2:0];
  assign w_pattern = {{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}};
  assign w_src     = i_pattern_sel ? w_pattern : i_color;
`else
  assign w_src     = i_color;
`endif

  // Blank every colour bit outside the active area.
  genvar gi;
  generate
    for (gi = 0; gi < 3 * CW; gi++) begin : g_gate
      assign w_rgb[gi] = r_de & w_src[gi];
    end
  endgenerate

  assign o_red         = w_rgb[3*CW-1 -: CW];
  assign o_green       = w_rgb[2*CW-1 -: CW];
  assign o_blue        = w_rgb[CW-1   -: CW];

  assign o_hsync       = r_hsync;
  assign o_vsync       = r_vsync;
  assign o_de          = r_de;
  assign o_x           = r_x;
  assign o_y           = r_y;
  assign o_pixel_ce    = r_pixel_ce;
  assign o_line_start  = r_line_start;
  assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: small-raster bench for vga_timing_gen.
// Raster is H 8/2/3/1 (14 clocks of pixels), V 4/1/2/1 (8 lines), PIX_DIV=2.
// A second instance with inverted sync polarity shares all inputs.
module tb_vga_timing_gen;

  localparam int CW = 4;

  logic        clk;
  logic        rst;
  logic        en;
  logic [11:0] color;
`ifdef VGA_TEST_PATTERN_EN
  logic        pat_sel;
  localparam logic PAT_ON = 1'b1;
`else
  localparam logic PAT_ON = 1'b0;
`endif

  logic        hs, vs, de, ce, ls, fs;
  logic [3:0]  x;
  logic [2:0]  y;
  logic [3:0]  r, g, b;

  logic        hs2, vs2, de2, ce2, ls2, fs2;
  logic [3:0]  x2;
  logic [2:0]  y2;
  logic [3:0]  r2, g2, b2;

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b0), .V_SYNC_POL(1'b0), .PIX_DIV(2), .CW(CW)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern_sel(pat_sel),
`endif
    .i_color(color),
    .o_hsync(hs), .o_vsync(vs), .o_de(de), .o_x(x), .o_y(y),
    .o_pixel_ce(ce), .o_line_start(ls), .o_frame_start(fs),
    .o_red(r), .o_green(g), .o_blue(b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .PIX_DIV(2), .CW(CW)
  ) dut_pol (
    .i_clk(clk), .i_reset(rst), .i_enable(en),
`ifdef VGA_TEST_PATTERN_EN
    .i_pattern_sel(pat_sel),
`endif
    .i_color(color),
    .o_hsync(hs2), .o_vsync(vs2), .o_de(de2), .o_x(x2), .o_y(y2),
    .o_pixel_ce(ce2), .o_line_start(ls2), .o_frame_start(fs2),
    .o_red(r2), .o_green(g2), .o_blue(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected output set; hs/vs are in the active-low sense of the main DUT.
  typedef struct packed {
    logic [3:0]  x;
    logic [2:0]  y;
    logic        de;
    logic        hs;
    logic        vs;
    logic        ce;
    logic        ls;
    logic        fs;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    int          cyc;
    logic [11:0] color;
    exp_t        e;
  } vec_t;

  vec_t tbl[$];
  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic exp_t mk(input int ex, input int ey, input logic ede, input logic ehs,
                              input logic evs, input logic ece, input logic els,
                              input logic efs, input logic [11:0] ergb);
    exp_t m;
    m.x = 4'(ex); m.y = 3'(ey); m.de = ede; m.hs = ehs; m.vs = evs;
    m.ce = ece; m.ls = els; m.fs = efs; m.rgb = ergb;
    return m;
  endfunction

  function automatic logic [11:0] bar_color(input int h);
    case (h)
      0: return 12'h000;
      1: return 12'h00F;
      2: return 12'h0F0;
      3: return 12'h0FF;
      4: return 12'hF00;
      5: return 12'hF0F;
      6: return 12'hFF0;
      default: return 12'hFFF;
    endcase
  endfunction

  // Closed-form expectation for the n-th clock after the raster (re)starts.
  function automatic exp_t model(input int n, input logic [11:0] col, input logic pat);
    exp_t m;
    int p, h, v;
    logic tick;
    p = n / 2;
    h = p % 14;
    v = (p / 14) % 8;
    tick = (n % 2 == 0);
    m.x  = 4'(h);
    m.y  = 3'(v);
    m.de = (h < 8) && (v < 4);
    m.hs = !((h >= 10) && (h <= 12));
    m.vs = !((v >= 5) && (v <= 6));
    m.ce = tick;
    m.ls = tick && (h == 0);
    m.fs = tick && (h == 0) && (v == 0);
    m.rgb = m.de ? (pat ? bar_color(h) : col) : 12'h000;
    return m;
  endfunction

  function automatic string fmt(input exp_t e);
    return $sformatf("x=%0d y=%0d de=%b hs=%b vs=%b ce=%b ls=%b fs=%b rgb=%h",
                     e.x, e.y, e.de, e.hs, e.vs, e.ce, e.ls, e.fs, e.rgb);
  endfunction

  // Compare both instances against one expectation; dut_pol syncs are inverted.
  task automatic compare(input string name, input int n, input exp_t e);
    exp_t a1, a2;
    a1 = mk(int'(x), int'(y), de, hs, vs, ce, ls, fs, {r, g, b});
    a2 = mk(int'(x2), int'(y2), de2, ~hs2, ~vs2, ce2, ls2, fs2, {r2, g2, b2});
    checks++;
    if (a1 !== e) begin
      failures++;
      $display("FAIL %s n=%0d got %s expected %s", name, n, fmt(a1), fmt(e));
    end
    checks++;
    if (a2 !== e) begin
      failures++;
      $display("FAIL %s_pol n=%0d got %s expected(syncs inverted) %s", name, n, fmt(a2), fmt(e));
    end
  endtask

  task automatic pop_compare(input string name, input int n);
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s n=%0d got empty scoreboard expected an entry", name, n);
    end else begin
      e = sb_q.pop_front();
      compare(name, n, e);
    end
  endtask

  // Drive count clocks of running raster from relative cycle n0, checking each.
  task automatic run_cycles(input int n0, input int count, input logic pat, input bit use_tbl);
    int n, ti, last_fs, last_ls;
    last_fs = -1;
    last_ls = -1;
    for (int k = 0; k < count; k++) begin
      n  = n0 + k;
      ti = -1;
      if (use_tbl)
        for (int i = 0; i < tbl.size(); i++)
          if (tbl[i].cyc == n) ti = i;
      color = (ti >= 0) ? tbl[ti].color : 12'($urandom);
`ifdef VGA_TEST_PATTERN_EN
      pat_sel = pat;
`endif
      sb_q.push_back(model(n, color, pat));
      @(posedge clk);
      @(negedge clk);
      pop_compare("sweep", n);
      if (ti >= 0) compare("vector", n, tbl[ti].e);
      if (fs) begin
        if (last_fs >= 0) begin
          checks++;
          if (n - last_fs != 224) begin
            failures++;
            $display("FAIL frame_period n=%0d got %0d expected 224", n, n - last_fs);
          end
        end
        last_fs = n;
      end
      if (ls) begin
        if (last_ls >= 0) begin
          checks++;
          if (n - last_ls != 28) begin
            failures++;
            $display("FAIL line_period n=%0d got %0d expected 28", n, n - last_ls);
          end
        end
        last_ls = n;
      end
    end
  endtask

  initial begin
    // Hand-derived vectors for the first 226 clocks after reset release.
    tbl.push_back('{0,   12'h123, mk(0, 0, 1, 1, 1, 1, 1, 1, 12'h123)});
    tbl.push_back('{1,   12'h456, mk(0, 0, 1, 1, 1, 0, 0, 0, 12'h456)});
    tbl.push_back('{14,  12'hABC, mk(7, 0, 1, 1, 1, 1, 0, 0, 12'hABC)});
    tbl.push_back('{16,  12'hFFF, mk(8, 0, 0, 1, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{18,  12'hFFF, mk(9, 0, 0, 1, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{20,  12'hFFF, mk(10, 0, 0, 0, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{23,  12'hFFF, mk(11, 0, 0, 0, 1, 0, 0, 0, 12'h000)});
    tbl.push_back('{24,  12'hFFF, mk(12, 0, 0, 0, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{26,  12'hFFF, mk(13, 0, 0, 1, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{28,  12'h0F0, mk(0, 1, 1, 1, 1, 1, 1, 0, 12'h0F0)});
    tbl.push_back('{112, 12'hFFF, mk(0, 4, 0, 1, 1, 1, 1, 0, 12'h000)});
    tbl.push_back('{140, 12'hFFF, mk(0, 5, 0, 1, 0, 1, 1, 0, 12'h000)});
    tbl.push_back('{150, 12'hFFF, mk(5, 5, 0, 1, 0, 1, 0, 0, 12'h000)});
    tbl.push_back('{168, 12'hFFF, mk(0, 6, 0, 1, 0, 1, 1, 0, 12'h000)});
    tbl.push_back('{196, 12'hFFF, mk(0, 7, 0, 1, 1, 1, 1, 0, 12'h000)});
    tbl.push_back('{210, 12'hFFF, mk(7, 7, 0, 1, 1, 1, 0, 0, 12'h000)});
    tbl.push_back('{224, 12'h0F0, mk(0, 0, 1, 1, 1, 1, 1, 1, 12'h0F0)});
    tbl.push_back('{225, 12'h00F, mk(0, 0, 1, 1, 1, 0, 0, 0, 12'h00F)});

    rst   = 1'b1;
    en    = 1'b1;
    color = 12'hFFF;
`ifdef VGA_TEST_PATTERN_EN
    pat_sel = 1'b0;
`endif
    @(negedge clk);
    compare("reset_state", -1, mk(0, 0, 0, 1, 1, 0, 0, 0, 12'h000));
    @(negedge clk);
    rst = 1'b0;

    // Two full frames plus a few clocks.
    run_cycles(0, 452, 1'b0, 1'b1);
    // Continue into the third frame up to (x=5, y=2).
    run_cycles(452, 63, 1'b0, 1'b0);

    // Drop enable: raster parks at origin, blanked, syncs inactive.
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      color = 12'($urandom);
      sb_q.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 12'h000));
      @(posedge clk);
      @(negedge clk);
      pop_compare("enable_low", k);
    end
    en = 1'b1;
    run_cycles(0, 40, PAT_ON, 1'b0);

    // Asynchronous reset mid-line while the active area shows full white.
    color = 12'hFFF;
`ifdef VGA_TEST_PATTERN_EN
    pat_sel = 1'b0;
`endif
    #1;
    compare("pre_reset", -1, mk(5, 1, 1, 1, 1, 0, 0, 0, 12'hFFF));
    #1;
    rst = 1'b1;
    #1;
    compare("async_reset", -1, mk(0, 0, 0, 1, 1, 0, 0, 0, 12'h000));
    @(negedge clk);
    compare("reset_held", -1, mk(0, 0, 0, 1, 1, 0, 0, 0, 12'h000));
    rst = 1'b0;
    run_cycles(0, 30, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
